// File: rtl/clash_pkg.sv
// Shared definitions for the card-deploy logic: unit indices, unit FSM states,
// the elixir cost table and the legal deploy field on screen.
package clash_pkg;

  localparam int NUM_UNITS = 4;

  typedef enum logic [1:0] {
    UNIT_AND  = 2'd0,
    UNIT_OR   = 2'd1,
    UNIT_NOT  = 2'd2,
    UNIT_NERD = 2'd3
  } unit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_DEPLOY = 2'd2,
    ST_ACTIVE = 2'd3
  } unit_state_t;

  // Indexed by unit_t: AND, OR, NOT, NERD.
  localparam logic [3:0] COST [NUM_UNITS] = '{4'd3, 4'd3, 4'd2, 4'd4};

  localparam logic [9:0] FIELD_X_MIN = 10'd320;
  localparam logic [9:0] FIELD_X_MAX = 10'd559;
  localparam logic [9:0] FIELD_Y_MIN = 10'd32;
  localparam logic [9:0] FIELD_Y_MAX = 10'd447;

  function automatic logic in_field(input logic [9:0] x, input logic [9:0] y);
    return (x >= FIELD_X_MIN) && (x <= FIELD_X_MAX) &&
           (y >= FIELD_Y_MIN) && (y <= FIELD_Y_MAX);
  endfunction

endpackage

// File: rtl/deploy_manager_if.sv
// Player-input and unit-control bundle between the game front end and deploy_manager.
interface deploy_manager_if;
  logic       vsync;
  logic       game_active;
  logic [3:0] key_sel;
  logic       mouse_btn;
  logic       cancel;
  logic [9:0] MouseX;
  logic [9:0] MouseY;
  logic [3:0] unit_dead;
  logic [3:0] idlein;
  logic [3:0] instatein;
  logic [3:0] deployin;
  logic [3:0] elixir;

  modport master (
    output vsync, game_active, key_sel, mouse_btn, cancel, MouseX, MouseY, unit_dead,
    input  idlein, instatein, deployin, elixir
  );

  modport slave (
    input  vsync, game_active, key_sel, mouse_btn, cancel, MouseX, MouseY, unit_dead,
    output idlein, instatein, deployin, elixir
  );
endinterface

// File: rtl/elixir_counter.sv
// Frame-driven elixir regeneration with same-cycle deduction; clears while the
// match is inactive.
module elixir_counter #(
  parameter int FRAMES_PER_ELIXIR = 60,
  parameter int ELIXIR_MAX        = 10,
  parameter int ELIXIR_START      = 5
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       game_active,
  input  logic       frame_tick,
  input  logic [3:0] deduct,
  output logic [3:0] elixir
);

  localparam int CNT_W = (FRAMES_PER_ELIXIR > 1) ? $clog2(FRAMES_PER_ELIXIR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_ELIXIR - 1);

  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [3:0]       elixir_reg, elixir_next;
  logic [4:0]       sum;
  logic             wrap;

  assign wrap = frame_tick && (frame_cnt_reg == CNT_LAST);

  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    elixir_next    = elixir_reg;
    // deduct never exceeds elixir_reg, so the 5-bit sum cannot underflow
    sum = {1'b0, elixir_reg} - {1'b0, deduct} + {4'd0, wrap};
    if (!game_active) begin
      frame_cnt_next = '0;
      elixir_next    = 4'(ELIXIR_START);
    end else begin
      if (frame_tick) begin
        frame_cnt_next = wrap ? '0 : frame_cnt_reg + CNT_W'(1);
      end
      elixir_next = (sum > 5'(ELIXIR_MAX)) ? 4'(ELIXIR_MAX) : sum[3:0];
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= '0;
      elixir_reg    <= 4'(ELIXIR_START);
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      elixir_reg    <= elixir_next;
    end
  end

  assign elixir = elixir_reg;

endmodule

// File: rtl/deploy_manager.sv
// Card selection and deployment: one IDLE/HELD/DEPLOY/ACTIVE FSM per unit,
// gated by cursor position and the shared elixir pool.
module deploy_manager
  import clash_pkg::*;
#(
  parameter int FRAMES_PER_ELIXIR = 60,
  parameter int ELIXIR_MAX        = 10,
  parameter int ELIXIR_START      = 5
) (
  input  logic             Clk,
  input  logic             reset_n,
  deploy_manager_if.slave  dm
);

  logic                 vsync_d_reg, mouse_d_reg;
  logic                 frame_tick, click_ok;
  logic [NUM_UNITS-1:0] sel_fire, deploy_go;
  logic [NUM_UNITS-1:0] idle_vec, held_vec, deploy_vec;
  logic [3:0]           deduct, elixir_val;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d_reg <= 1'b0;
      mouse_d_reg <= 1'b0;
    end else begin
      vsync_d_reg <= dm.vsync;
      mouse_d_reg <= dm.mouse_btn;
    end
  end

  assign frame_tick = dm.vsync & ~vsync_d_reg;
  assign click_ok   = dm.game_active & dm.mouse_btn & ~mouse_d_reg &
                      in_field(dm.MouseX, dm.MouseY);

  // A selection only takes effect for a single key aimed at an idle unit.
  assign sel_fire = (dm.game_active && $onehot(dm.key_sel)) ? (dm.key_sel & idle_vec) : '0;

  always_comb begin
    deduct = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (deploy_go[i]) deduct = deduct | COST[i];
    end
  end

  elixir_counter #(
    .FRAMES_PER_ELIXIR (FRAMES_PER_ELIXIR),
    .ELIXIR_MAX        (ELIXIR_MAX),
    .ELIXIR_START      (ELIXIR_START)
  ) u_elixir (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .game_active (dm.game_active),
    .frame_tick  (frame_tick),
    .deduct      (deduct),
    .elixir      (elixir_val)
  );

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : gen_unit
    unit_state_t state_reg, state_next;
    logic        tick_seen_reg, tick_seen_next;
    logic        idle_reg, held_reg, deploy_reg;

    // Cancel beats a new selection, which beats a click on the same cycle.
    assign deploy_go[gi] = (state_reg == ST_HELD) && dm.game_active && !dm.cancel &&
                           !(|sel_fire) && click_ok &&
                           (elixir_val >= COST[unit_t'(gi)]);

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg     <= ST_IDLE;
        tick_seen_reg <= 1'b0;
      end else begin
        state_reg     <= state_next;
        tick_seen_reg <= tick_seen_next;
      end
    end

    always_comb begin
      state_next     = state_reg;
      tick_seen_next = tick_seen_reg;
      if (!dm.game_active) begin
        state_next     = ST_IDLE;
        tick_seen_next = 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (sel_fire[gi]) state_next = ST_HELD;
          end
          ST_HELD: begin
            if (dm.cancel || (|sel_fire)) begin
              state_next = ST_IDLE;
            end else if (deploy_go[gi]) begin
              state_next     = ST_DEPLOY;
              tick_seen_next = 1'b0;
            end
          end
          ST_DEPLOY: begin
            // Leave one cycle after the first frame tick seen while deploying.
            if (tick_seen_reg) begin
              state_next     = ST_ACTIVE;
              tick_seen_next = 1'b0;
            end else if (frame_tick) begin
              tick_seen_next = 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (dm.unit_dead[gi]) state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
        idle_reg   <= 1'b1;
        held_reg   <= 1'b0;
        deploy_reg <= 1'b0;
      end else begin
        idle_reg   <= (state_next == ST_IDLE);
        held_reg   <= (state_next == ST_HELD);
        deploy_reg <= (state_next == ST_DEPLOY);
      end
    end

    assign idle_vec[gi]   = idle_reg;
    assign held_vec[gi]   = held_reg;
    assign deploy_vec[gi] = deploy_reg;
  end

  assign dm.idlein    = idle_vec;
  assign dm.instatein = held_vec;
  assign dm.deployin  = deploy_vec;
  assign dm.elixir    = elixir_val;

endmodule

// File: tb/tb_deploy_manager.sv
// Directed bench for deploy_manager: elixir regeneration, selection, deploy,
// rejection, cancel, wrap-cycle deduction, inactive clear and async reset.
module tb_deploy_manager;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  deploy_manager_if dm();

  deploy_manager dut (
    .Clk     (clk),
    .reset_n (rst_n),
    .dm      (dm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      dm.vsync = 1'b1;
      step();
      dm.vsync = 1'b0;
      step();
    end
  endtask

  task automatic click(input int x, input int y);
    dm.MouseX    = 10'(x);
    dm.MouseY    = 10'(y);
    dm.mouse_btn = 1'b1;
    step();
    dm.mouse_btn = 1'b0;
    step();
  endtask

  task automatic select(input logic [3:0] k);
    dm.key_sel = k;
    step();
    dm.key_sel = 4'b0000;
  endtask

  task automatic kill(input logic [3:0] m);
    dm.unit_dead = m;
    step();
    dm.unit_dead = 4'b0000;
  endtask

  task automatic restart_match();
    dm.game_active = 1'b0;
    step();
    dm.game_active = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    dm.vsync       = 1'b0;
    dm.game_active = 1'b1;
    dm.key_sel     = 4'b0000;
    dm.mouse_btn   = 1'b0;
    dm.cancel      = 1'b0;
    dm.MouseX      = 10'd0;
    dm.MouseY      = 10'd0;
    dm.unit_dead   = 4'b0000;
    step();
    step();
    check("rst_idlein", dm.idlein, 4'b1111);
    check("rst_instatein", dm.instatein, 4'b0000);
    check("rst_deployin", dm.deployin, 4'b0000);
    check("rst_elixir", dm.elixir, 4'd5);
    rst_n = 1'b1;
    step();

    // regeneration: +1 per 60 ticks, saturating at 10
    tick(59);  check("regen_59", dm.elixir, 4'd5);
    tick(1);   check("regen_60", dm.elixir, 4'd6);
    tick(239); check("regen_299", dm.elixir, 4'd9);
    tick(1);   check("regen_300", dm.elixir, 4'd10);
    tick(60);  check("regen_sat", dm.elixir, 4'd10);

    restart_match();
    check("inactive_elixir", dm.elixir, 4'd5);

    // AND deploy lifecycle
    select(4'b0001);
    check("and_held", dm.instatein, 4'b0001);
    check("and_idle_vec", dm.idlein, 4'b1110);
    click(400, 200);
    check("and_deploy", dm.deployin, 4'b0001);
    check("and_cost", dm.elixir, 4'd2);
    dm.vsync = 1'b1; step();
    check("and_deploy_on_tick", dm.deployin, 4'b0001);
    dm.vsync = 1'b0; step();
    check("and_active_deploy", dm.deployin, 4'b0000);
    check("and_active_idle", dm.idlein, 4'b1110);
    kill(4'b0001); step();
    check("and_dead_idle", dm.idlein, 4'b1111);

    // NOT deploy to drain elixir to 0, then regenerate to 1
    select(4'b0100);
    click(400, 200);
    check("not_cost", dm.elixir, 4'd0);
    tick(1);
    kill(4'b0100); step();
    tick(57);  check("drain_wait", dm.elixir, 4'd0);
    tick(1);   check("drain_regen", dm.elixir, 4'd1);

    // NOT with insufficient elixir is rejected
    select(4'b0100);
    check("poor_held", dm.instatein, 4'b0100);
    click(400, 200);
    check("poor_still_held", dm.instatein, 4'b0100);
    check("poor_elixir", dm.elixir, 4'd1);
    check("poor_no_deploy", dm.deployin, 4'b0000);
    dm.cancel = 1'b1; step(); dm.cancel = 1'b0;
    check("poor_cancel", dm.idlein, 4'b1111);

    // NERD held with 8 elixir; out-of-field clicks rejected, then switch to OR
    restart_match();
    tick(180); check("elixir_8", dm.elixir, 4'd8);
    select(4'b1000);
    check("nerd_held", dm.instatein, 4'b1000);
    click(100, 200);
    click(319, 200);
    click(560, 200);
    click(400, 31);
    click(400, 448);
    check("outside_held", dm.instatein, 4'b1000);
    check("outside_elixir", dm.elixir, 4'd8);
    check("outside_no_deploy", dm.deployin, 4'b0000);
    select(4'b0010);
    check("switch_held", dm.instatein, 4'b0010);
    check("switch_idle", dm.idlein, 4'b1101);
    click(559, 447);
    check("corner_max_deploy", dm.deployin, 4'b0010);
    check("corner_max_cost", dm.elixir, 4'd5);
    kill(4'b0010); step();
    check("dead_ignored_deploy", dm.deployin, 4'b0010);
    tick(1);
    check("or_active", dm.idlein, 4'b1101);
    kill(4'b0010); step();
    check("or_dead_idle", dm.idlein, 4'b1111);

    // cancel wins over a simultaneous click; multi-key select ignored
    select(4'b0001);
    dm.MouseX = 10'd400; dm.MouseY = 10'd200;
    dm.cancel = 1'b1; dm.mouse_btn = 1'b1;
    step();
    dm.cancel = 1'b0; dm.mouse_btn = 1'b0;
    step();
    check("cancel_idle", dm.idlein, 4'b1111);
    check("cancel_elixir", dm.elixir, 4'd5);
    check("cancel_no_deploy", dm.deployin, 4'b0000);
    select(4'b0011);
    check("multikey_ignored", dm.instatein, 4'b0000);

    // deduction on the regeneration wrap cycle, then match ends mid-deploy
    restart_match();
    select(4'b0100);
    click(320, 32);
    check("corner_min_cost", dm.elixir, 4'd3);
    tick(1);
    kill(4'b0100); step();
    tick(58);  check("pre_wrap", dm.elixir, 4'd3);
    select(4'b0100);
    dm.MouseX = 10'd400; dm.MouseY = 10'd200;
    dm.vsync = 1'b1; dm.mouse_btn = 1'b1;
    step();
    check("wrap_deduct", dm.elixir, 4'd2);
    check("wrap_deploy", dm.deployin, 4'b0100);
    dm.vsync = 1'b0; dm.mouse_btn = 1'b0;
    step();
    check("entry_tick_not_counted", dm.deployin, 4'b0100);
    dm.game_active = 1'b0;
    step();
    check("inactive_idlein", dm.idlein, 4'b1111);
    check("inactive_deployin", dm.deployin, 4'b0000);
    check("inactive_elixir5", dm.elixir, 4'd5);
    select(4'b0001);
    check("inactive_key_ignored", dm.instatein, 4'b0000);
    dm.game_active = 1'b1;
    step();

    // asynchronous reset mid-deploy
    select(4'b0001);
    click(400, 200);
    check("pre_reset_deploy", dm.deployin, 4'b0001);
    check("pre_reset_elixir", dm.elixir, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_deployin", dm.deployin, 4'b0000);
    check("async_idlein", dm.idlein, 4'b1111);
    check("async_elixir", dm.elixir, 4'd5);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
